// File: rtl/knn_dist_calc_pkg.sv
// knn_dist_calc_pkg: shared defaults and FSM state encoding for the k-NN
// distance stage.
package knn_dist_calc_pkg;

    localparam int W_DEF  = 32;
    localparam int CW_DEF = W_DEF / 2;
    localparam int NW_DEF = W_DEF / 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/knn_dist_calc_sq_diff.sv
// knn_dist_calc_sq_diff: one axis of the distance datapath.
// Cycle 1 registers a-b (CW+1 signed); cycle 2 registers its square
// (2CW+2 unsigned). Free-running; validity is tracked by the caller.
module knn_dist_calc_sq_diff #(
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [CW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic [2*CW+1:0]      sq_o
);

    logic signed [CW:0]     diff_q;
    logic signed [2*CW+1:0] dext;
    logic signed [2*CW+1:0] prod;
    logic [2*CW+1:0]        sq_q;

    // Square in full 2CW+2 precision so the largest |diff| = 2^CW fits.
    always_comb begin
        dext = {{(CW+1){diff_q[CW]}}, diff_q};
        prod = dext * dext;
    end

    // Pipeline registers: difference, then square.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
            sq_q   <= '0;
        end else begin
            diff_q <= {a_i[CW-1], a_i} - {b_i[CW-1], b_i};
            sq_q   <= $unsigned(prod);
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/knn_dist_calc.sv
// knn_dist_calc: squared Euclidean distance between a latched test point and
// a stream of training points. Accept at t -> valid_out at t+2 -> dist_out
// at t+3. Optional feature macro: KNN_DIST_SAT_EN (saturate to 2^W-1
// instead of wrapping to W bits).
module knn_dist_calc
    import knn_dist_calc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = W / 2,
    parameter int NW = W / 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NW-1:0]        n_points,
    input  logic signed [CW-1:0] test_x,
    input  logic signed [CW-1:0] test_y,
    input  logic signed [CW-1:0] train_x,
    input  logic signed [CW-1:0] train_y,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic                 valid_out,
    output logic signed [W:0]    dist_out,
    output logic                 busy,
    output logic                 done
);

    localparam int SW = 2 * CW + 2;
    localparam int EW = (SW > W + 1) ? SW : W + 1;
    localparam logic [W-1:0] DIST_MAX = '1;

    state_e                      state_q, state_d;
    logic [NW-1:0]               n_q, cnt_q;
    logic [1:0][CW-1:0]          test_q;
    logic [1:0][CW-1:0]          train;
    logic [1:0][SW-1:0]          sq;
    logic [2:1]                  vld_pipe_q;
    logic [W:0]                  dist_q, dist_d;
    logic [EW-1:0]               sum;
    logic                        room, accept, last_acc;

    assign room     = (state_q == ST_RUN) && (cnt_q != n_q);
    assign accept   = room && valid_in;
    assign last_acc = accept && (({1'b0, cnt_q} + 1'b1) == {1'b0, n_q});
    assign train    = {train_y, train_x};

    // One squared-difference lane per axis (0 = x, 1 = y).
    for (genvar a = 0; a < 2; a++) begin : g_axis
        knn_dist_calc_sq_diff #(.CW(CW)) u_sq (
            .clk  (clk),
            .rst  (rst),
            .a_i  (train[a]),
            .b_i  (test_q[a]),
            .sq_o (sq[a])
        );
    end

    // Final add and reduction of the sum to W+1 bits (MSB always 0).
    always_comb begin
        sum = EW'(sq[0]) + EW'(sq[1]);
`ifdef KNN_DIST_SAT_EN
        dist_d = (sum > EW'(DIST_MAX)) ? (W+1)'(DIST_MAX) : (W+1)'(sum);
`else
        dist_d = (W+1)'(sum & EW'(DIST_MAX));
`endif
    end

    // Next-state logic; DRAIN waits until the last dist has been shown.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:           if ((cnt_q == n_q) || last_acc) state_d = ST_DRAIN;
            ST_DRAIN:         if (vld_pipe_q == '0) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // State, run configuration, accept counter, valid pipe and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            test_q     <= '0;
            vld_pipe_q <= '0;
            dist_q     <= '0;
        end else begin
            state_q    <= state_d;
            vld_pipe_q <= {vld_pipe_q[1], accept};
            if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
                n_q    <= n_points;
                cnt_q  <= '0;
                test_q <= {test_y, test_x};
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (vld_pipe_q[2]) dist_q <= dist_d;
        end
    end

    assign ready_in  = room;
    assign valid_out = vld_pipe_q[2];
    assign dist_out  = $signed(dist_q);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_knn_dist_calc.sv
// tb_knn_dist_calc: randomized and directed stimulus for knn_dist_calc,
// checked against a plain-arithmetic distance model plus a software k-NN rank.
module tb_knn_dist_calc;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam int NW = 8;

    logic                 clk, rst, start, valid_in;
    logic [NW-1:0]        n_points;
    logic signed [CW-1:0] test_x, test_y, train_x, train_y;
    logic                 ready_in, valid_out, busy, done;
    logic [W:0]           dist_out;

    knn_dist_calc #(.W(W), .CW(CW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .test_x(test_x), .test_y(test_y), .train_x(train_x), .train_y(train_y),
        .valid_in(valid_in), .ready_in(ready_in), .valid_out(valid_out),
        .dist_out(dist_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: squared Euclidean distance reduced to W bits.
    function automatic longint dist_ref(input int tx, input int ty, input int px, input int py);
        longint dx, dy, s;
        dx = longint'(px) - longint'(tx);
        dy = longint'(py) - longint'(ty);
        s  = dx * dx + dy * dy;
`ifdef KNN_DIST_SAT_EN
        return (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
`else
        return s & 64'hFFFF_FFFF;
`endif
    endfunction

    typedef struct { int c; longint d; } exp_t;
    exp_t   q[$];
    longint got_list[$];
    int     cyc = 0;
    int     last_acc = 0;
    int     mtx = 0, mty = 0;
    bit     pend = 0;
    longint pend_d = 0, hold_exp = 0;

    always @(posedge clk) cyc++;

    // Scoreboard: valid_out two cycles after accept, dist_out the cycle after, then held.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend) begin
                hold_exp = pend_d;
                got_list.push_back(longint'(dist_out));
                pend = 0;
            end
            chk("dist_out", longint'(dist_out), hold_exp);
            if (valid_out) begin
                if (q.size() == 0) chk("valid_out_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("valid_out_cycle", cyc, e.c);
                    pend = 1;
                    pend_d = e.d;
                end
            end
            if (valid_in && ready_in) begin
                q.push_back('{cyc + 2, dist_ref(mtx, mty, int'(train_x), int'(train_y))});
                last_acc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input int tx, input int ty);
        start = 1'b1; n_points = NW'(n); test_x = CW'(tx); test_y = CW'(ty);
        mtx = tx; mty = ty;
        tick();
        start = 1'b0;
    endtask

    // Feed points; gap idle cycles after each accept, optional stray start in the gap.
    task automatic feed(input int xs[$], input int ys[$], input int gap, input bit stray);
        int i = 0, g = 0;
        bit acc;
        while (i < xs.size() && g < 1000) begin
            valid_in = 1'b1; train_x = CW'(xs[i]); train_y = CW'(ys[i]);
            @(negedge clk);
            acc = ready_in;
            tick();
            g++;
            if (acc) begin
                i++;
                valid_in = 1'b0;
                for (int k = 0; k < gap; k++) begin
                    if (stray && k == 0) begin
                        start = 1'b1; n_points = NW'(1); test_x = CW'(100); test_y = CW'(-7);
                    end
                    tick();
                    start = 1'b0;
                end
            end
        end
        valid_in = 1'b0;
        if (i < xs.size()) chk("feed_timeout", i, xs.size());
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!done && g < 50) begin tick(); g++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_latency"}, cyc - last_acc, 4);
    endtask

    initial begin
        int xs[$], ys[$];
        int busy_cnt, rdy_seen, tx6, ty6;
        longint dv[12], mv[12];
        int di[12], mi[12];

        rst = 1'b1; start = 1'b0; valid_in = 1'b0; n_points = '0;
        test_x = '0; test_y = '0; train_x = '0; train_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready_in, 0); chk("rst_vout", valid_out, 0);
        chk("rst_dist", dist_out, 0);  chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Abort mid-run with two points in flight.
        do_start(5, 0, 0);
        xs = '{1, 2}; ys = '{1, 2};
        feed(xs, ys, 0, 0);
        tick();
        chk("abort_vout_before", valid_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", ready_in, 0); chk("abort_vout", valid_out, 0);
        chk("abort_dist", dist_out, 0);  chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        q.delete(); pend = 0; hold_exp = 0;
        #10 rst = 1'b0;
        repeat (6) tick();
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);

        // Directed distances 25, 2, 4 back-to-back.
        got_list.delete();
        do_start(3, 0, 0);
        xs = '{3, 1, -2}; ys = '{4, 1, 0};
        feed(xs, ys, 0, 0);
        wait_done("t2");
        chk("t2_count", got_list.size(), 3);
        if (got_list.size() == 3) begin
            chk("t2_d0", got_list[0], 25);
            chk("t2_d1", got_list[1], 2);
            chk("t2_d2", got_list[2], 4);
        end
        chk("t2_done_hold", dist_out, 4);

        // Empty run.
        do_start(0, 5, 5);
        busy_cnt = 0; rdy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            busy_cnt += int'(busy); rdy_seen |= int'(ready_in);
            tick();
        end
        chk("t3_busy_cycles", busy_cnt, 2);
        chk("t3_ready_never", rdy_seen, 0);
        chk("t3_done", done, 1);

        // Extreme coordinates.
        got_list.delete();
        do_start(1, -32768, -32768);
        xs = '{32767}; ys = '{32767};
        feed(xs, ys, 0, 0);
        wait_done("t4");
        chk("t4_count", got_list.size(), 1);
`ifdef KNN_DIST_SAT_EN
        if (got_list.size() == 1) chk("t4_sat", got_list[0], 64'hFFFF_FFFF);
`else
        if (got_list.size() == 1) chk("t4_wrap", got_list[0], 64'hFFFC_0002);
`endif

        // Gapped input with stray start pulses during RUN.
        got_list.delete();
        do_start(4, 10, -20);
        xs.delete(); ys.delete();
        for (int k = 0; k < 4; k++) begin
            xs.push_back($urandom_range(0, 4000) - 2000);
            ys.push_back($urandom_range(0, 4000) - 2000);
        end
        feed(xs, ys, 2, 1);
        wait_done("t5");
        chk("t5_count", got_list.size(), 4);

        // 12 random points ranked by a software k-NN model.
        got_list.delete();
        tx6 = $urandom_range(0, 2000) - 1000;
        ty6 = $urandom_range(0, 2000) - 1000;
        do_start(12, tx6, ty6);
        xs.delete(); ys.delete();
        for (int k = 0; k < 12; k++) begin
            xs.push_back($urandom_range(0, 2000) - 1000);
            ys.push_back($urandom_range(0, 2000) - 1000);
        end
        feed(xs, ys, 0, 0);
        wait_done("t6");
        chk("t6_count", got_list.size(), 12);
        if (got_list.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                dv[k] = got_list[k];
                mv[k] = dist_ref(tx6, ty6, xs[k], ys[k]);
                di[k] = k; mi[k] = k;
            end
            for (int a = 0; a < 11; a++)
                for (int b = 0; b < 11 - a; b++) begin
                    if (dv[di[b]] > dv[di[b+1]]) begin int t = di[b]; di[b] = di[b+1]; di[b+1] = t; end
                    if (mv[mi[b]] > mv[mi[b+1]]) begin int t = mi[b]; mi[b] = mi[b+1]; mi[b+1] = t; end
                end
            for (int k = 0; k < 12; k++) chk($sformatf("t6_rank%0d", k), di[k], mi[k]);
        end

        chk("end_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
